// File: rtl/lab5_pkg.sv
// Shared types and widths for the lab5 instruction fetch path.
package lab5_pkg;

    localparam int LAB5_ADDR_W = 8;
    localparam int LAB5_DATA_W = 16;
    localparam int FBUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [LAB5_ADDR_W-1:0] pc;
        logic [LAB5_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/lab5_fbuf.sv
// Two-entry fetch FIFO; flush invalidates contents and wins over enq/deq.
module lab5_fbuf
    import lab5_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         enq,
    input  logic         deq,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [1:0]   count
);

    fetch_entry_t ent [FBUF_DEPTH];
    logic         head;
    logic         tail;

    // Head only moves when another entry will sit behind it, so an empty
    // buffer keeps presenting the last delivered word.
    assign tail = head ^ count[0];
    assign dout = ent[head];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            head   <= 1'b0;
            ent[0] <= '0;
            ent[1] <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            if (enq)
                ent[tail] <= din;
            if (deq && (count[1] || enq))
                head <= ~head;
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

endmodule

// File: rtl/lab5_ifetch.sv
// Instruction fetch unit: PC, fetch FSM, buffer control and fetch counter.
module lab5_ifetch
    import lab5_pkg::*;
#(
    parameter int ADDR_W = LAB5_ADDR_W,
    parameter int DATA_W = LAB5_DATA_W,
    parameter int DEPTH  = FBUF_DEPTH
) (
    input  logic              CLK,
    input  logic              RESET,
    output logic [ADDR_W-1:0] IRAM_ADDR,
    input  logic [DATA_W-1:0] IRAM_Q,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_INSTR,
    output logic [ADDR_W-1:0] OUT_PC,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    input  logic              HALT,
    output logic [15:0]       FETCH_CNT
);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [1:0]        count;
    logic              fetch_en;
    logic              enq;
    logic              deq;
    fetch_entry_t      din;
    fetch_entry_t      dout;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            state <= S_WAIT;
        else
            state <= state_nxt;
    end

    // A redirect freezes RUN/HALTED; the post-reset WAIT cycle always advances.
    always_comb begin
        state_nxt = state;
        case (state)
            S_WAIT:   state_nxt = HALT ? S_HALTED : S_RUN;
            S_RUN:    if (!REDIRECT && HALT)  state_nxt = S_HALTED;
            S_HALTED: if (!REDIRECT && !HALT) state_nxt = S_RUN;
            default:  state_nxt = S_WAIT;
        endcase
    end

    always_comb begin
        fetch_en = (state == S_RUN) && !HALT && !REDIRECT;
    end

    assign OUT_VALID = (count != 2'd0);
    assign deq       = OUT_VALID && OUT_READY && !REDIRECT;
    assign enq       = fetch_en && (count < 2'(DEPTH) || deq);
    assign din       = '{pc: pc, instr: IRAM_Q};

    lab5_fbuf u_fbuf (
        .clk   (CLK),
        .rst   (RESET),
        .enq   (enq),
        .deq   (deq),
        .flush (REDIRECT),
        .din   (din),
        .dout  (dout),
        .count (count)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            pc <= '0;
        else if (REDIRECT)
            pc <= {REDIRECT_PC[ADDR_W-1:1], 1'b0};
        else if (enq)
            pc <= pc + ADDR_W'(2);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            FETCH_CNT <= '0;
        else if (enq && FETCH_CNT != 16'hFFFF)
            FETCH_CNT <= FETCH_CNT + 16'd1;
    end

    assign IRAM_ADDR = pc;
    assign OUT_INSTR = dout.instr;
    assign OUT_PC    = dout.pc;

endmodule

// File: tb/tb_lab5_ifetch.sv
// Randomized bench for lab5_ifetch against a queue-based fetch model.
module tb_lab5_ifetch;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] instr;
    } ent_t;

    logic        CLK;
    logic        RESET;
    logic [7:0]  IRAM_ADDR;
    logic [15:0] IRAM_Q;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [15:0] OUT_INSTR;
    logic [7:0]  OUT_PC;
    logic        REDIRECT;
    logic [7:0]  REDIRECT_PC;
    logic        HALT;
    logic [15:0] FETCH_CNT;

    logic [15:0] mem [128];

    ent_t        q[$];
    int          m_mode;   // 0 = wait, 1 = run, 2 = halted
    logic [7:0]  m_pc;
    int          m_cnt;

    int n_tests;
    int n_fail;

    lab5_ifetch dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .IRAM_ADDR   (IRAM_ADDR),
        .IRAM_Q      (IRAM_Q),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_INSTR   (OUT_INSTR),
        .OUT_PC      (OUT_PC),
        .REDIRECT    (REDIRECT),
        .REDIRECT_PC (REDIRECT_PC),
        .HALT        (HALT),
        .FETCH_CNT   (FETCH_CNT)
    );

    assign IRAM_Q = mem[IRAM_ADDR[7:1]];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_mode = 0;
        m_pc   = 8'h00;
        m_cnt  = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_addr"},  32'(IRAM_ADDR), 32'(m_pc));
        chk({tag, "_valid"}, 32'(OUT_VALID), 32'(q.size() > 0));
        chk({tag, "_cnt"},   32'(FETCH_CNT), 32'(m_cnt));
        if (q.size() > 0) begin
            chk({tag, "_instr"}, 32'(OUT_INSTR), 32'(q[0].instr));
            chk({tag, "_pc"},    32'(OUT_PC),    32'(q[0].pc));
        end
    endtask

    // Called at a negedge: check, drive this cycle's inputs, advance model,
    // return at the following negedge.
    task automatic step(input bit rdy, input bit hlt, input bit rd, input logic [7:0] rpc, input string tag);
        bit   deq;
        bit   fetch;
        ent_t e;
        check_all(tag);
        OUT_READY   = rdy;
        HALT        = hlt;
        REDIRECT    = rd;
        REDIRECT_PC = rpc;
        deq = (q.size() > 0) && rdy;
        if (rd) begin
            q.delete();
            m_pc = rpc & 8'hFE;
            if (m_mode == 0)
                m_mode = hlt ? 2 : 1;
        end else begin
            fetch = (m_mode == 1) && !hlt && (q.size() < 2 || deq);
            if (deq)
                void'(q.pop_front());
            if (fetch) begin
                e.pc    = m_pc;
                e.instr = mem[m_pc >> 1];
                q.push_back(e);
                m_pc = m_pc + 8'd2;
                if (m_cnt < 65535)
                    m_cnt++;
            end
            m_mode = hlt ? 2 : 1;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] exp3 [3];
        logic [7:0]  pc_hold;
        int          cnt_hold;
        int          halt_left;
        bit          rdy;
        bit          hlt;
        bit          rd;

        n_tests = 0;
        n_fail  = 0;
        RESET = 1'b1;
        OUT_READY = 1'b0;
        HALT = 1'b0;
        REDIRECT = 1'b0;
        REDIRECT_PC = 8'h00;
        for (int i = 0; i < 128; i++)
            mem[i] = 16'($urandom);
        mem[0]  = 16'hF491;
        mem[1]  = 16'hF249;
        mem[2]  = 16'h52BF;
        mem[21] = 16'hF20C;
        exp3[0] = 16'hF491;
        exp3[1] = 16'hF249;
        exp3[2] = 16'h52BF;

        repeat (2) @(negedge CLK);
        chk("rst_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_instr", 32'(OUT_INSTR), 32'd0);
        chk("rst_pc",    32'(OUT_PC),    32'd0);
        chk("rst_addr",  32'(IRAM_ADDR), 32'd0);
        chk("rst_cnt",   32'(FETCH_CNT), 32'd0);
        RESET = 1'b0;
        model_reset();

        // Start-up stream
        step(1, 0, 0, 8'h00, "wait");
        chk("start_addr", 32'(IRAM_ADDR), 32'h00);
        chk("start_valid", 32'(OUT_VALID), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 8'h00, "start");
            chk("start_seq_instr", 32'(OUT_INSTR), 32'(exp3[i]));
            chk("start_seq_pc",    32'(OUT_PC),    32'(2 * i));
        end

        // Backpressure from reset
        do_reset();
        repeat (5) step(0, 0, 0, 8'h00, "bp");
        chk("bp_addr_frozen", 32'(IRAM_ADDR), 32'h04);
        chk("bp_cnt", 32'(FETCH_CNT), 32'd2);
        for (int i = 0; i < 3; i++) begin
            chk("bp_seq_valid", 32'(OUT_VALID), 32'd1);
            chk("bp_seq_instr", 32'(OUT_INSTR), 32'(exp3[i]));
            step(1, 0, 0, 8'h00, "bp_drain");
        end

        // Redirect with a full buffer
        repeat (2) step(0, 0, 0, 8'h00, "rd_fill");
        chk("rd_full", 32'(OUT_VALID), 32'd1);
        step(0, 0, 1, 8'h2B, "rd");
        chk("rd_flush_valid", 32'(OUT_VALID), 32'd0);
        chk("rd_addr", 32'(IRAM_ADDR), 32'h2A);
        step(1, 0, 0, 8'h00, "rd_fetch");
        chk("rd_word_valid", 32'(OUT_VALID), 32'd1);
        chk("rd_word_instr", 32'(OUT_INSTR), 32'hF20C);
        chk("rd_word_pc",    32'(OUT_PC),    32'h2A);

        // Halt mid-stream
        repeat (3) step(1, 0, 0, 8'h00, "pre_halt");
        cnt_hold = m_cnt;
        pc_hold  = m_pc;
        repeat (4) step(1, 1, 0, 8'h00, "halt");
        chk("halt_cnt_frozen", 32'(FETCH_CNT), 32'(cnt_hold));
        chk("halt_drained", 32'(OUT_VALID), 32'd0);
        chk("halt_pc_held", 32'(IRAM_ADDR), 32'(pc_hold));
        step(1, 0, 0, 8'h00, "unhalt");
        step(1, 0, 0, 8'h00, "resume");
        chk("resume_pc", 32'(OUT_PC), 32'(pc_hold));

        // PC wrap
        step(1, 0, 1, 8'hFC, "wrap_rd");
        step(1, 0, 0, 8'h00, "wrap0");
        chk("wrap_pc0", 32'(OUT_PC), 32'hFC);
        step(1, 0, 0, 8'h00, "wrap1");
        chk("wrap_pc1", 32'(OUT_PC), 32'hFE);
        step(1, 0, 0, 8'h00, "wrap2");
        chk("wrap_pc2", 32'(OUT_PC), 32'h00);

        // Random traffic
        halt_left = 0;
        for (int i = 0; i < 1500; i++) begin
            rdy = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 99) < 4);
            if (halt_left > 0) begin
                hlt = 1'b1;
                halt_left--;
            end else begin
                hlt = 1'b0;
                if ($urandom_range(0, 49) == 0)
                    halt_left = $urandom_range(1, 6);
            end
            step(rdy, hlt, rd, 8'($urandom), "rand");
        end

        // Asynchronous reset with a full buffer
        repeat (3) step(0, 0, 0, 8'h00, "ar_fill");
        chk("ar_full", 32'(OUT_VALID), 32'd1);
        #2 RESET = 1'b1;
        #1;
        chk("ar_valid", 32'(OUT_VALID), 32'd0);
        chk("ar_addr",  32'(IRAM_ADDR), 32'd0);
        chk("ar_cnt",   32'(FETCH_CNT), 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        model_reset();
        repeat (4) step(1, 0, 0, 8'h00, "ar_restart");
        check_all("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
